// File: rtl/gshare_predictor.sv
// Gshare branch predictor: a PHT of saturating counters indexed by PC xor global
// history, plus a direct-mapped BTB indexed by PC bits alone.
module gshare_predictor #(
  parameter int XLEN       = 64,
  parameter int INDEX_BITS = 6,
  parameter int HIST_BITS  = 6,
  parameter int CTR_BITS   = 2,
  parameter int TAG_BITS   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [XLEN-1:0]      pc_fetch_i,
  input  logic [XLEN-1:0]      pc_execution_i,
  input  logic [HIST_BITS-1:0] ghr_exec_i,
  input  logic                 is_branch_EX_i,
  input  logic                 branch_taken_result_exec_i,
  input  logic [XLEN-1:0]      branch_addr_result_exec_i,
  output logic                 predict_taken_o,
  output logic [XLEN-1:0]      predict_addr_o,
  output logic [HIST_BITS-1:0] ghr_o
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_LO  = INDEX_BITS + 2;
  localparam int TAG_HI  = INDEX_BITS + TAG_BITS + 1;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;

  logic [CTR_BITS-1:0]  pht_q [ENTRIES];
  logic [CTR_BITS-1:0]  pht_d [ENTRIES];
  logic [ENTRIES-1:0]   btb_valid_q, btb_valid_d;
  logic [TAG_BITS-1:0]  btb_tag_q [ENTRIES];
  logic [XLEN-1:0]      btb_tgt_q [ENTRIES];
  logic [HIST_BITS-1:0] ghr_q, ghr_d;

  logic [INDEX_BITS-1:0] fetch_idx, fetch_btb_idx, upd_idx, upd_btb_idx;
  logic [TAG_BITS-1:0]   fetch_tag, upd_tag;
  logic [HIST_BITS-1:0]  ghr_repaired;
  logic                  btb_hit;
  logic                  btb_we;
  logic                  unused_ok;

  assign fetch_btb_idx = pc_fetch_i[INDEX_BITS+1:2];
  assign upd_btb_idx   = pc_execution_i[INDEX_BITS+1:2];
  assign fetch_idx     = fetch_btb_idx ^ INDEX_BITS'(ghr_q);
  assign upd_idx       = upd_btb_idx ^ INDEX_BITS'(ghr_exec_i);
  assign fetch_tag     = pc_fetch_i[TAG_HI:TAG_LO];
  assign upd_tag       = pc_execution_i[TAG_HI:TAG_LO];

  // History is rebuilt from the snapshot that travelled with the branch, which
  // discards any speculative shifts made since that branch was fetched.
  generate
    if (HIST_BITS == 1) begin : g_hist_one
      assign ghr_repaired = branch_taken_result_exec_i;
    end else begin : g_hist_many
      assign ghr_repaired = {ghr_exec_i[HIST_BITS-2:0], branch_taken_result_exec_i};
    end
  endgenerate

  always_comb begin
    // NOTE: every always_comb target gets a full default first so no latch is inferred.
    pht_d       = pht_q;
    btb_valid_d = btb_valid_q;
    ghr_d       = ghr_q;
    if (is_branch_EX_i) begin
      if (branch_taken_result_exec_i) begin
        if (pht_q[upd_idx] != CTR_MAX) pht_d[upd_idx] = pht_q[upd_idx] + 1'b1;
        btb_valid_d[upd_btb_idx] = 1'b1;
      end else if (pht_q[upd_idx] != '0) begin
        pht_d[upd_idx] = pht_q[upd_idx] - 1'b1;
      end
      ghr_d = ghr_repaired;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples pre-edge values and the read-before-write ordering holds.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= CTR_INIT;
      btb_valid_q <= '0;
      ghr_q       <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) pht_q[i] <= pht_d[i];
      btb_valid_q <= btb_valid_d;
      ghr_q       <= ghr_d;
    end
  end

  assign btb_we = is_branch_EX_i && branch_taken_result_exec_i && !rst_i;

  // NOTE: tag/target storage is a plain memory without reset; the valid bits
  // alone decide whether an entry can hit.
  always_ff @(posedge clk_i) begin
    if (btb_we) begin
      btb_tag_q[upd_btb_idx] <= upd_tag;
      btb_tgt_q[upd_btb_idx] <= branch_addr_result_exec_i;
    end
  end

  assign btb_hit         = btb_valid_q[fetch_btb_idx] && (btb_tag_q[fetch_btb_idx] == fetch_tag);
  assign predict_taken_o = btb_hit && pht_q[fetch_idx][CTR_BITS-1];
  assign predict_addr_o  = btb_hit ? btb_tgt_q[fetch_btb_idx] : pc_fetch_i + XLEN'(4);
  assign ghr_o           = ghr_q;

  // Execute-side PC bits outside the index/tag fields carry no information here.
  assign unused_ok = ^{pc_execution_i, ghr_exec_i};

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: a table of per-cycle vectors followed by
// hand-written reset and same-cycle read/write sequences.
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] pc_fetch = '0;
  logic [63:0] pc_exec = '0;
  logic [5:0]  ghr_exec = '0;
  logic        is_branch = 1'b0;
  logic        taken = 1'b0;
  logic [63:0] target = '0;
  logic        pred_taken;
  logic [63:0] pred_addr;
  logic [5:0]  ghr;

  int n_checks = 0;
  int n_fail   = 0;

  gshare_predictor dut (
    .clk_i                      (clk),
    .rst_i                      (rst),
    .pc_fetch_i                 (pc_fetch),
    .pc_execution_i             (pc_exec),
    .ghr_exec_i                 (ghr_exec),
    .is_branch_EX_i             (is_branch),
    .branch_taken_result_exec_i (taken),
    .branch_addr_result_exec_i  (target),
    .predict_taken_o            (pred_taken),
    .predict_addr_o             (pred_addr),
    .ghr_o                      (ghr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        br;
    logic        tk;
    logic [63:0] pc_ex;
    logic [5:0]  ghr_ex;
    logic [63:0] tgt;
    logic [63:0] pc_f;
    logic        exp_tk;
    logic [63:0] exp_addr;
    logic [5:0]  exp_ghr;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic etk, input logic [63:0] eaddr,
                            input logic [5:0] eghr);
    check({name, ".taken"}, 64'(pred_taken), 64'(etk));
    check({name, ".addr"}, pred_addr, eaddr);
    check({name, ".ghr"}, 64'(ghr), 64'(eghr));
  endtask

  initial begin
    // br tk pc_ex ghr_ex tgt pc_fetch | exp_taken exp_addr exp_ghr
    vecs[0]  = '{0, 1, 64'h1000, 6'h00, 64'h3000, 64'h1000, 0, 64'h1004, 6'h00}; // idle ignores exec inputs
    vecs[1]  = '{1, 1, 64'h1000, 6'h00, 64'h2000, 64'h1000, 1, 64'h2000, 6'h01}; // learn taken
    vecs[2]  = '{1, 1, 64'h1000, 6'h00, 64'h2000, 64'h1000, 1, 64'h2000, 6'h01};
    vecs[3]  = '{1, 1, 64'h1000, 6'h00, 64'h2000, 64'h1000, 1, 64'h2000, 6'h01};
    vecs[4]  = '{1, 1, 64'h1000, 6'h00, 64'h2000, 64'h1000, 1, 64'h2000, 6'h01}; // ctr[0] = 3
    vecs[5]  = '{1, 0, 64'h1000, 6'h00, 64'h2000, 64'h1000, 1, 64'h2000, 6'h00}; // ctr 2
    vecs[6]  = '{1, 0, 64'h1000, 6'h00, 64'h2000, 64'h1000, 0, 64'h2000, 6'h00}; // ctr 1
    vecs[7]  = '{1, 0, 64'h1000, 6'h00, 64'h2000, 64'h1000, 0, 64'h2000, 6'h00}; // ctr 0
    vecs[8]  = '{1, 0, 64'h1000, 6'h00, 64'h2000, 64'h1000, 0, 64'h2000, 6'h00}; // stays 0
    vecs[9]  = '{1, 1, 64'h1000, 6'h00, 64'h2000, 64'h1000, 1, 64'h2000, 6'h01}; // ctr 1, reads idx 1
    vecs[10] = '{1, 0, 64'h1000, 6'h20, 64'h2000, 64'h1000, 0, 64'h2000, 6'h00}; // ghr back to 0, ctr[0]=1
    vecs[11] = '{0, 0, 64'h0,    6'h00, 64'h0,    64'h1100, 0, 64'h1104, 6'h00}; // tag miss
    vecs[12] = '{1, 1, 64'h3040, 6'h1F, 64'h4000, 64'h3040, 1, 64'h4000, 6'h3F}; // ghr = 3F
    vecs[13] = '{1, 0, 64'h3040, 6'h05, 64'h4000, 64'h3040, 1, 64'h4000, 6'h0A}; // history repair
    vecs[14] = '{0, 0, 64'h0,    6'h00, 64'h0,    64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 6'h0A}; // +4 wraps

    // Asynchronous reset asserted mid-cycle.
    pc_fetch = 64'h1000;
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check_outs("reset_async", 1'b0, 64'h1004, 6'h00);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      is_branch = vecs[i].br;
      taken     = vecs[i].tk;
      pc_exec   = vecs[i].pc_ex;
      ghr_exec  = vecs[i].ghr_ex;
      target    = vecs[i].tgt;
      pc_fetch  = vecs[i].pc_f;
      @(posedge clk);
      #1 is_branch = 1'b0;
      check_outs($sformatf("vec%0d", i), vecs[i].exp_tk, vecs[i].exp_addr, vecs[i].exp_ghr);
    end

    // Same-cycle read and write of one entry: old result now, new one after the edge.
    @(negedge clk);
    is_branch = 1'b1; taken = 1'b1; pc_exec = 64'h5000; ghr_exec = 6'h0A; target = 64'h6000;
    pc_fetch  = 64'h5000;
    #1 check_outs("rw_same_old", 1'b0, 64'h5004, 6'h0A);
    @(posedge clk);
    #1 is_branch = 1'b0;
    check_outs("rw_same_new", 1'b0, 64'h6000, 6'h15);

    // Reset arriving while an update is presented discards it.
    @(negedge clk);
    is_branch = 1'b1; taken = 1'b1; pc_exec = 64'h7000; ghr_exec = 6'h00; target = 64'h8000;
    #2 rst = 1'b1;
    #1 check_outs("rst_mid_upd", 1'b0, 64'h5004, 6'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; is_branch = 1'b0; pc_fetch = 64'h7000;
    #1 check_outs("rst_discard", 1'b0, 64'h7004, 6'h00);

    // First edge after release behaves normally.
    @(negedge clk);
    is_branch = 1'b1; taken = 1'b1; pc_exec = 64'h7000; ghr_exec = 6'h00; target = 64'h8000;
    @(posedge clk);
    #1 is_branch = 1'b0;
    check_outs("post_release", 1'b1, 64'h8000, 6'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 SHALL have parameter XLEN, default 64: PC and target width.
REQ-002 SHALL have parameter INDEX_BITS, default 6: PHT/BTB index width; entries = 2**INDEX_BITS.
REQ-003 SHALL have parameter HIST_BITS, default 6: global history width; legal range 1..INDEX_BITS.
REQ-004 SHALL have parameter CTR_BITS, default 2: saturating counter width; legal range 2..4.
REQ-005 SHALL have parameter TAG_BITS, default 8: BTB tag width, taken from pc[INDEX_BITS+2+TAG_BITS-1 : INDEX_BITS+2].
REQ-006 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-008 SHALL have port pc_fetch_i  input  XLEN  fetch-stage PC to predict.
REQ-009 SHALL have port pc_execution_i  input  XLEN  PC of the resolving instruction.
REQ-010 SHALL have port ghr_exec_i  input  HIST_BITS  history snapshot carried with the resolving branch.
REQ-011 SHALL have port is_branch_EX_i  input  1  execute stage resolves a conditional branch this cycle.
REQ-012 SHALL have port branch_taken_result_exec_i  input  1  resolved direction.
REQ-013 SHALL have port branch_addr_result_exec_i  input  XLEN  resolved target.
REQ-014 SHALL have port predict_taken_o  output  1  predicted taken.
REQ-015 SHALL have port predict_addr_o  output  XLEN  predicted target.
REQ-016 SHALL have port ghr_o  output  HIST_BITS  current history, which the pipeline carries to ghr_exec_i.

Function
REQ-017 SHALL compute the fetch index as pc_fetch_i[INDEX_BITS+1:2] XOR zero-extended GHR.
REQ-018 SHALL compute the update index as pc_execution_i[INDEX_BITS+1:2] XOR zero-extended ghr_exec_i.
REQ-019 SHALL keep per entry: a CTR_BITS counter (PHT) plus valid bit, tag and XLEN target (BTB); the BTB is indexed by PC bits only, not XORed.
REQ-020 SHALL read combinationally (zero latency); a same-cycle write to the read entry is not visible until the next cycle.
REQ-021 SHALL drive predict_taken_o = BTB hit AND counter MSB, where hit = valid AND tag match.
REQ-022 SHALL drive predict_addr_o = BTB target on hit, else pc_fetch_i + 4 (modulo 2**XLEN).
REQ-023 SHALL, when is_branch_EX_i=1, increment the counter on taken and decrement it on not-taken, saturating at 2**CTR_BITS-1 and at 0.
REQ-024 SHALL, when is_branch_EX_i=1 and taken=1, write valid=1, tag and target into the BTB entry; no BTB write occurs otherwise.
REQ-025 SHALL, when is_branch_EX_i=1, load GHR <= {ghr_exec_i[HIST_BITS-2:0], taken}; for HIST_BITS=1 GHR <= taken. This repairs speculative skew.
REQ-026 SHALL hold all state when is_branch_EX_i=0, regardless of the other execute inputs.
REQ-027 SHALL give an update precedence over nothing else: reads and writes of different or identical indices in one cycle are both legal.

Reset
REQ-028 SHALL, while rst_i=1, asynchronously set every counter to weakly taken (1 << (CTR_BITS-1)), clear every BTB valid bit, and clear GHR to 0.
REQ-029 SHALL output predict_taken_o=0, predict_addr_o=pc_fetch_i+4 and ghr_o=0 during reset; BTB tags and targets need not reset.
REQ-030 SHALL, on assertion mid-update, discard the update; the first post-release edge behaves as normal.

Verification
REQ-031 SHALL cover reset: assert rst_i asynchronously, pc_fetch_i=0x1000 -> predict_taken_o=0, predict_addr_o=0x1004, ghr_o=0.
REQ-032 SHALL cover learn-taken: one taken update, pc=0x1000, target=0x2000, ghr_exec_i=0 -> next cycle at fetch 0x1000 with GHR=1 the BTB hits; the bench checks predict_addr_o=0x2000 and ghr_o=0x01.
REQ-033 SHALL cover saturation: four taken updates on one index (2-bit counter) -> counter=3; three not-taken updates -> counter=0 and predict_taken_o=0; a further not-taken update stays at 0.
REQ-034 SHALL cover tag miss: train pc=0x1000, then fetch 0x1000+(1<<(INDEX_BITS+2)) -> predict_taken_o=0, predict_addr_o=fetch+4.
REQ-035 SHALL cover history repair: with GHR=0x3F, an update with ghr_exec_i=0x05 and taken=0 -> ghr_o=0x0A.
REQ-036 SHALL cover same-cycle read/write of one index: the old prediction is returned that cycle and the new prediction appears the next cycle.
